// File: rtl/memory_bist.sv
// March-style BIST controller (W0, R0W1, R1W0, R0) driving a single-port memory macro.
// Define BIST_FAIL_LOG_EN to capture the address and read data of the first mismatch of a run.
module memory_bist #(
    parameter int ADDR_BITS = 5,
    parameter int DATA_BITS = 8,
    parameter int ERR_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DATA_BITS-1:0] pattern,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_BITS-1:0]  err_count,
    output logic [ADDR_BITS-1:0] fail_addr,
    output logic [DATA_BITS-1:0] fail_data,
    output logic                 mem_we,
    output logic                 mem_shift_enable,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [DATA_BITS-1:0] mem_wdata,
    input  logic [DATA_BITS-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_W0,
        S_R0W1,
        S_R1W0,
        S_R0,
        S_DONE
    } state_t;

    localparam logic [ADDR_BITS-1:0] ADDR_LAST = '1;

    state_t               state_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic                 wr_q;      // second (write) cycle of a two-cycle element
    logic [DATA_BITS-1:0] pat_q;
    logic [ERR_BITS-1:0]  err_q;
    logic                 done_q;

    logic                 rd_cycle;
    logic [DATA_BITS-1:0] exp_data;
    logic                 mismatch;
    logic                 start_acc;

    always_comb begin
        rd_cycle  = (state_q == S_R0) ||
                    (((state_q == S_R0W1) || (state_q == S_R1W0)) && !wr_q);
        exp_data  = (state_q == S_R1W0) ? ~pat_q : pat_q;
        mismatch  = rd_cycle && (mem_rdata != exp_data);
        start_acc = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            pat_q   <= '0;
            err_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            if (mismatch && (err_q != '1)) begin
                err_q <= err_q + ERR_BITS'(1);
            end
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        pat_q   <= pattern;
                        err_q   <= '0;
                        done_q  <= 1'b0;
                        addr_q  <= '0;
                        wr_q    <= 1'b0;
                        state_q <= S_W0;
                    end
                end
                S_W0: begin
                    if (addr_q == ADDR_LAST) begin
                        addr_q  <= '0;
                        state_q <= S_R0W1;
                    end else begin
                        addr_q <= addr_q + ADDR_BITS'(1);
                    end
                end
                S_R0W1: begin
                    wr_q <= !wr_q;
                    if (wr_q) begin
                        if (addr_q == ADDR_LAST) begin
                            state_q <= S_R1W0;
                        end else begin
                            addr_q <= addr_q + ADDR_BITS'(1);
                        end
                    end
                end
                S_R1W0: begin
                    wr_q <= !wr_q;
                    if (wr_q) begin
                        if (addr_q == '0) begin
                            state_q <= S_R0;
                        end else begin
                            addr_q <= addr_q - ADDR_BITS'(1);
                        end
                    end
                end
                S_R0: begin
                    if (addr_q == ADDR_LAST) begin
                        addr_q  <= '0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        addr_q <= addr_q + ADDR_BITS'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    addr_q  <= '0;
                    wr_q    <= 1'b0;
                end
            endcase
        end
    end

`ifdef BIST_FAIL_LOG_EN
    logic [ADDR_BITS-1:0] faddr_q;
    logic [DATA_BITS-1:0] fdata_q;

    // err_q==0 identifies the first mismatch; saturation never returns it to zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            faddr_q <= '0;
            fdata_q <= '0;
        end else if (start_acc) begin
            faddr_q <= '0;
            fdata_q <= '0;
        end else if (mismatch && (err_q == '0)) begin
            faddr_q <= addr_q;
            fdata_q <= mem_rdata;
        end
    end

    assign fail_addr = faddr_q;
    assign fail_data = fdata_q;
`else
    assign fail_addr = '0;
    assign fail_data = '0;
`endif

    assign busy             = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done             = done_q;
    assign pass             = done_q && (err_q == '0);
    assign err_count        = err_q;
    assign mem_shift_enable = 1'b0;
    assign mem_addr         = addr_q;
    assign mem_we           = (state_q == S_W0) ||
                              (((state_q == S_R0W1) || (state_q == S_R1W0)) && wr_q);
    assign mem_wdata        = ((state_q == S_R0W1) && wr_q) ? ~pat_q : pat_q;

endmodule

// File: tb/tb_memory_bist.sv
// Self-checking bench for memory_bist: fault-injecting memory model, vector table,
// randomized runs against a March reference model, and start-ignore / mid-run reset sequences.
module tb_memory_bist;

    localparam int AB = 5;
    localparam int DB = 8;
    localparam int N  = 1 << AB;
    localparam int RUN_CYC = 6 * N;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [DB-1:0] pattern;
    logic          busy, done, pass;
    logic [7:0]    err_count;
    logic [AB-1:0] fail_addr;
    logic [DB-1:0] fail_data;
    logic          mem_we, mem_shift_enable;
    logic [AB-1:0] mem_addr;
    logic [DB-1:0] mem_wdata;
    logic [DB-1:0] mem_rdata;

    logic          s_busy, s_done, s_pass;
    logic [3:0]    s_err;
    logic [AB-1:0] s_faddr;
    logic [DB-1:0] s_fdata;
    logic          s_we, s_shift;
    logic [AB-1:0] s_addr;
    logic [DB-1:0] s_wdata;

    always #5 clk = ~clk;

    memory_bist #(.ADDR_BITS(AB), .DATA_BITS(DB), .ERR_BITS(8)) u_dut (
        .clk(clk), .rst(rst), .start(start), .pattern(pattern),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .fail_addr(fail_addr), .fail_data(fail_data),
        .mem_we(mem_we), .mem_shift_enable(mem_shift_enable),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // second instance: narrow counter, memory that always reads 0x00
    memory_bist #(.ADDR_BITS(AB), .DATA_BITS(DB), .ERR_BITS(4)) u_sat (
        .clk(clk), .rst(rst), .start(start), .pattern(8'hA5),
        .busy(s_busy), .done(s_done), .pass(s_pass), .err_count(s_err),
        .fail_addr(s_faddr), .fail_data(s_fdata),
        .mem_we(s_we), .mem_shift_enable(s_shift),
        .mem_addr(s_addr), .mem_wdata(s_wdata), .mem_rdata(8'h00)
    );

    logic [DB-1:0] mem [N];
    logic [DB-1:0] s1  [N];
    logic [DB-1:0] s0  [N];

    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
    always_comb mem_rdata = (mem[mem_addr] | s1[mem_addr]) & ~s0[mem_addr];

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic set_fault(input int a, input logic [DB-1:0] m1, input logic [DB-1:0] m0);
        for (int i = 0; i < N; i++) begin
            s1[i] = '0;
            s0[i] = '0;
        end
        s1[a] = m1;
        s0[a] = m0 & ~m1;
    endtask

    // Reference: run the March algorithm over a faulty array in plain loops
    task automatic model(input logic [DB-1:0] p, output int err, output int fa,
                         output logic [DB-1:0] fd);
        logic [DB-1:0] m [N];
        logic [DB-1:0] r;
        err = 0; fa = 0; fd = '0;
        for (int a = 0; a < N; a++) m[a] = p;
        for (int pass_no = 0; pass_no < 3; pass_no++) begin
            for (int k = 0; k < N; k++) begin
                int a;
                logic [DB-1:0] e;
                a = (pass_no == 1) ? N - 1 - k : k;
                e = (pass_no == 1) ? ~p : p;
                r = (m[a] | s1[a]) & ~s0[a];
                if (r != e) begin
                    if (err == 0) begin fa = a; fd = r; end
                    if (err < 255) err++;
                end
                if (pass_no == 0) m[a] = ~p;
                if (pass_no == 1) m[a] = p;
            end
        end
    endtask

    typedef struct {
        logic          we;
        int            addr;
        logic [DB-1:0] wd;
    } slot_t;
    slot_t exp_seq [RUN_CYC];

    task automatic build_seq(input logic [DB-1:0] p);
        int i = 0;
        for (int a = 0; a < N; a++) begin exp_seq[i] = '{1'b1, a, p}; i++; end
        for (int a = 0; a < N; a++) begin
            exp_seq[i] = '{1'b0, a, p};  i++;
            exp_seq[i] = '{1'b1, a, ~p}; i++;
        end
        for (int a = N - 1; a >= 0; a--) begin
            exp_seq[i] = '{1'b0, a, p}; i++;
            exp_seq[i] = '{1'b1, a, p}; i++;
        end
        for (int a = 0; a < N; a++) begin exp_seq[i] = '{1'b0, a, p}; i++; end
    endtask

    // Start a run, log per-cycle memory controls, return busy-cycle count and slot mismatches
    task automatic run_one(input logic [DB-1:0] p, input int glitch_at,
                           output int cyc, output int seq_errs);
        build_seq(p);
        @(negedge clk);
        pattern = p;
        start   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0;
        seq_errs = 0;
        for (int t = 0; t < 2 * RUN_CYC; t++) begin
            @(negedge clk);
            if (done) break;
            if (busy) begin
                if (cyc < RUN_CYC) begin
                    if (mem_we !== exp_seq[cyc].we || int'(mem_addr) != exp_seq[cyc].addr ||
                        mem_wdata !== exp_seq[cyc].wd) seq_errs++;
                end else begin
                    seq_errs++;
                end
                cyc++;
            end
            if (mem_shift_enable !== 1'b0) seq_errs++;
            if (cyc == glitch_at) begin
                start   = 1'b1;
                pattern = ~p;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
    endtask

    task automatic check_result(input string tag, input int cyc, input int seq_errs,
                                input int e_err, input int e_fa, input logic [DB-1:0] e_fd);
        chk({tag, " run_cycles"}, cyc, RUN_CYC);
        chk({tag, " addr_seq"}, seq_errs, 0);
        chk({tag, " done"}, done, 1);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " err_count"}, err_count, e_err);
        chk({tag, " pass"}, pass, (e_err == 0) ? 1 : 0);
`ifdef BIST_FAIL_LOG_EN
        chk({tag, " fail_addr"}, fail_addr, e_fa);
        chk({tag, " fail_data"}, fail_data, e_fd);
`else
        chk({tag, " fail_addr"}, fail_addr, 0);
        chk({tag, " fail_data"}, fail_data, 0);
        if (e_fa < 0 && e_fd != 0) $display("unused");
`endif
    endtask

    typedef struct {
        logic [DB-1:0] p;
        int            fa;
        logic [DB-1:0] m1;
        logic [DB-1:0] m0;
        int            e_err;
        int            e_faddr;
        logic [DB-1:0] e_fdata;
    } vec_t;

    initial begin
        vec_t vt [6];
        int cyc, se, me, mfa;
        logic [DB-1:0] mfd;

        vt[0] = '{8'h5A, 0,  8'h00, 8'h00, 0, 0,  8'h00};
        vt[1] = '{8'h00, 7,  8'h01, 8'h00, 2, 7,  8'h01};
        vt[2] = '{8'hFF, 3,  8'h00, 8'h80, 2, 3,  8'h7F};
        vt[3] = '{8'h0F, 31, 8'hF0, 8'h00, 2, 31, 8'hFF};
        vt[4] = '{8'hA5, 0,  8'h5A, 8'h00, 2, 0,  8'hFF};
        vt[5] = '{8'h00, 10, 8'h00, 8'h01, 1, 10, 8'hFE};

        set_fault(0, 8'h00, 8'h00);
        rst = 1'b1;
        start = 1'b0;
        pattern = '0;
        #3;
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst pass", pass, 0);
        chk("rst err_count", err_count, 0);
        chk("rst fail_addr", fail_addr, 0);
        chk("rst fail_data", fail_data, 0);
        chk("rst mem_we", mem_we, 0);
        chk("rst mem_addr", mem_addr, 0);
        chk("rst mem_wdata", mem_wdata, 0);
        chk("rst mem_shift", mem_shift_enable, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 6; v++) begin
            set_fault(vt[v].fa, vt[v].m1, vt[v].m0);
            run_one(vt[v].p, -1, cyc, se);
            check_result($sformatf("vec%0d", v), cyc, se, vt[v].e_err, vt[v].e_faddr, vt[v].e_fdata);
            if (v == 0) begin
                chk("sat done", s_done, 1);
                chk("sat err_count", s_err, 15);
                chk("sat pass", s_pass, 0);
            end
        end

        repeat (5) @(negedge clk);
        chk("hold done", done, 1);
        chk("hold mem_we", mem_we, 0);
        chk("hold mem_addr", mem_addr, 0);

        set_fault(7, 8'h01, 8'h00);
        run_one(8'h00, 50, cyc, se);
        check_result("glitch", cyc, se, 2, 7, 8'h01);

        for (int r = 0; r < 8; r++) begin
            logic [DB-1:0] p;
            p = DB'($urandom);
            set_fault($urandom_range(0, N - 1), DB'($urandom) & DB'($urandom), DB'($urandom) & DB'($urandom));
            if (r == 7) s1[$urandom_range(0, N - 1)] |= DB'($urandom);
            model(p, me, mfa, mfd);
            run_one(p, -1, cyc, se);
            check_result($sformatf("rand%0d", r), cyc, se, me, mfa, mfd);
        end

        set_fault(0, 8'h00, 8'h00);
        @(negedge clk);
        pattern = 8'h3C;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (70) @(negedge clk);
        chk("prerst mem_we", mem_we, 1);
        chk("prerst busy", busy, 1);
        #1 rst = 1'b1;
        #1;
        chk("midrst mem_we", mem_we, 0);
        chk("midrst busy", busy, 0);
        chk("midrst mem_addr", mem_addr, 0);
        chk("midrst done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        run_one(8'h5A, -1, cyc, se);
        check_result("postrst", cyc, se, 0, 0, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
